// File: rtl/rom_download_sequencer.sv
// rom_download_sequencer
//   Bridges the HPS ioctl download port to an arcade core's ROM write port.
//   Forwards download bytes, checks that addresses arrive in order and that the
//   image has exactly EXPECTED_BYTES bytes, and keeps the core in reset during a
//   download and for HOLD_CYCLES cycles after a good load or a user reset.
//
// Ports
//   CLK          system clock
//   RESET        asynchronous active-high reset
//   dn_download  high while the HPS is transferring an image
//   dn_wr        byte strobe; only its rising edge counts
//   dn_addr      byte address
//   dn_data      byte value
//   user_reset   level-sensitive core reset request
//   rom_addr     registered dn_addr[ADDR_W-1:0]
//   rom_data     registered dn_data
//   rom_wr       one-cycle write pulse per accepted byte
//   core_reset   registered reset to the core
//   busy         high while loading or checking
//   load_ok      sticky, set after a valid load
//   load_err     sticky, set after a rejected load
module rom_download_sequencer #(
   parameter int unsigned EXPECTED_BYTES = 49152,
   parameter int unsigned HOLD_CYCLES    = 1024,
   parameter int unsigned ADDR_W         = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              dn_download,
   input  logic              dn_wr,
   input  logic [24:0]       dn_addr,
   input  logic [7:0]        dn_data,
   input  logic              user_reset,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [7:0]        rom_data,
   output logic              rom_wr,
   output logic              core_reset,
   output logic              busy,
   output logic              load_ok,
   output logic              load_err
);

   localparam int unsigned CntW  = 17;
   localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StCheck, StHold, StRun} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [HoldW-1:0]  hold_q, hold_d;
   logic              err_q, err_d;
   logic              dn_wr_q, dn_download_q;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [7:0]        rom_data_q, rom_data_d;
   logic              rom_wr_q, rom_wr_d;
   logic              core_reset_q, core_reset_d;
   logic              load_ok_q, load_ok_d;
   logic              load_err_q, load_err_d;

   logic wr_edge, dl_rise, dl_fall;
   logic addr_match, in_range, addr_fits, bad_byte, start_load;

   assign wr_edge = dn_wr & ~dn_wr_q;
   assign dl_rise = dn_download & ~dn_download_q;
   assign dl_fall = ~dn_download & dn_download_q;

   assign addr_match = ({7'd0, dn_addr} == {15'd0, cnt_q});
   assign in_range   = ({7'd0, dn_addr} < EXPECTED_BYTES);
   assign addr_fits  = (({7'd0, dn_addr} >> ADDR_W) == 32'd0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      err_d      = err_q;
      rom_addr_d = rom_addr_q;
      rom_data_d = rom_data_q;
      rom_wr_d   = 1'b0;
      load_ok_d  = load_ok_q;
      load_err_d = load_err_q;
      bad_byte   = 1'b0;
      start_load = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (dl_rise) start_load = 1'b1;
         end
         StLoad: begin
            // A write coinciding with the end of download is still processed.
            if (wr_edge) begin
               bad_byte = ~addr_match | ~in_range;
               if (bad_byte) err_d = 1'b1;
               if (!bad_byte || addr_fits) begin
                  rom_wr_d   = 1'b1;
                  rom_addr_d = dn_addr[ADDR_W-1:0];
                  rom_data_d = dn_data;
               end
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end
            if (dl_fall) state_d = StCheck;
         end
         StCheck: begin
            if (dl_rise) begin
               start_load = 1'b1;
            end else if (({15'd0, cnt_q} == EXPECTED_BYTES) && !err_q) begin
               hold_d  = HoldLoad;
               state_d = StHold;
            end else begin
               load_err_d = 1'b1;
               state_d    = StIdle;
            end
         end
         StHold: begin
            if (dl_rise) begin
               start_load = 1'b1;
            end else if (user_reset) begin
               hold_d = HoldLoad;
            end else if (hold_q == '0) begin
               load_ok_d = 1'b1;
               state_d   = StRun;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         StRun: begin
            if (dl_rise) begin
               start_load = 1'b1;
            end else if (user_reset) begin
               hold_d  = HoldLoad;
               state_d = StHold;
            end
         end
         default: state_d = StIdle;
      endcase

      // A new download wins over everything else, in every state.
      if (start_load) begin
         state_d    = StLoad;
         cnt_d      = '0;
         err_d      = 1'b0;
         load_ok_d  = 1'b0;
         load_err_d = 1'b0;
      end

      core_reset_d = (state_d != StRun);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         hold_q        <= '0;
         err_q         <= 1'b0;
         dn_wr_q       <= 1'b0;
         // Reset high so a download still in progress across RESET is not seen
         // as a new one; the host must drop and re-raise dn_download.
         dn_download_q <= 1'b1;
         rom_addr_q    <= '0;
         rom_data_q    <= '0;
         rom_wr_q      <= 1'b0;
         core_reset_q  <= 1'b1;
         load_ok_q     <= 1'b0;
         load_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         hold_q        <= hold_d;
         err_q         <= err_d;
         dn_wr_q       <= dn_wr;
         dn_download_q <= dn_download;
         rom_addr_q    <= rom_addr_d;
         rom_data_q    <= rom_data_d;
         rom_wr_q      <= rom_wr_d;
         core_reset_q  <= core_reset_d;
         load_ok_q     <= load_ok_d;
         load_err_q    <= load_err_d;
      end
   end

   assign rom_addr   = rom_addr_q;
   assign rom_data   = rom_data_q;
   assign rom_wr     = rom_wr_q;
   assign core_reset = core_reset_q;
   assign busy       = (state_q == StLoad) || (state_q == StCheck);
   assign load_ok    = load_ok_q;
   assign load_err   = load_err_q;

endmodule
